// File: rtl/mem_arbiter_if.sv
// Requester, shared-response and memory-bus signals of mem_arbiter.
// master: arbiter side; slave: requesters plus memory side.
interface mem_arbiter_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BEAT_W = 3;

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_gnt;
    logic              ic_resp_valid;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_gnt;
    logic              dc_resp_valid;

    logic [DATA_W-1:0] resp_data;
    logic [BEAT_W-1:0] resp_beat;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic              bus_resp_valid;
    logic [DATA_W-1:0] bus_resp_data;
    logic              bus_resp_last;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr,
               bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_last,
        output ic_gnt, ic_resp_valid, dc_gnt, dc_resp_valid, resp_data, resp_beat,
               bus_req_valid, bus_addr, bus_we
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr,
               bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_last,
        input  ic_gnt, ic_resp_valid, dc_gnt, dc_resp_valid, resp_data, resp_beat,
               bus_req_valid, bus_addr, bus_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter for a single-outstanding memory bus.
// Default arbitration is round-robin; define ARB_DCACHE_PRIORITY_EN to make dc win ties.
module mem_arbiter (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master arb
);
    localparam int unsigned BEAT_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t state;
    logic   pick_dc;
    logic   beat_acc;
    logic   last_acc;

    assign beat_acc = (state == WAIT_RESP) && arb.bus_resp_valid;
    assign last_acc = beat_acc && arb.bus_resp_last;

`ifdef ARB_DCACHE_PRIORITY_EN
    assign pick_dc = arb.dc_req;
`else
    // rr_dc set means dc is preferred on the next tie
    logic rr_dc;

    assign pick_dc = arb.dc_req && (!arb.ic_req || rr_dc);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_dc <= 1'b0;
        end else if (last_acc) begin
            rr_dc <= !arb.dc_gnt;
        end
    end
`endif

    // Beats are forwarded in the same cycle to whoever holds the grant.
    assign arb.ic_resp_valid = !reset && beat_acc && arb.ic_gnt;
    assign arb.dc_resp_valid = !reset && beat_acc && arb.dc_gnt;
    assign arb.resp_data     = arb.bus_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            arb.ic_gnt        <= 1'b0;
            arb.dc_gnt        <= 1'b0;
            arb.bus_req_valid <= 1'b0;
            arb.bus_addr      <= '0;
            arb.bus_we        <= 1'b0;
            arb.resp_beat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    arb.resp_beat <= '0;
                    if (arb.ic_req || arb.dc_req) begin
                        state             <= ISSUE;
                        arb.ic_gnt        <= !pick_dc;
                        arb.dc_gnt        <= pick_dc;
                        arb.bus_req_valid <= 1'b1;
                        arb.bus_addr      <= pick_dc ? arb.dc_addr : arb.ic_addr;
                        arb.bus_we        <= pick_dc && arb.dc_we;
                    end
                end
                ISSUE: begin
                    if (arb.bus_req_ready) begin
                        state             <= WAIT_RESP;
                        arb.bus_req_valid <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    // Counter wraps 7->0 naturally on long bursts.
                    if (last_acc) begin
                        state         <= IDLE;
                        arb.ic_gnt    <= 1'b0;
                        arb.dc_gnt    <= 1'b0;
                        arb.resp_beat <= '0;
                    end else if (beat_acc) begin
                        arb.resp_beat <= arb.resp_beat + BEAT_W'(1);
                    end
                end
                default: begin
                    state             <= IDLE;
                    arb.ic_gnt        <= 1'b0;
                    arb.dc_gnt        <= 1'b0;
                    arb.bus_req_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
